delay_buf: RTL and testbench
============================

# delay_buf

Fixed-latency, enable-gated delay line that presents each input word at its output exactly DEPTH enabled clock cycles after capture. It is built as a chain of equal-length shift-register segments: one head segment plus DEPTH/SRLEN−1 body segments. It provides the DEPTH-sample (FFT_LEN) history delay inside the oversampled PFB datapath, in front of the FFT/phase-rotation stages.

## Interface
- DEPTH, default 64 (FFT_LEN): total delay in enabled cycles; must be a positive multiple of SRLEN.
- SRLEN, default 8: register count per segment; must be ≥ 1.
- WIDTH, default 16: data word width in bits.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- en  input  1  shift enable; when high, the whole chain advances one position.
- din  input  WIDTH  sample entering the head segment.
- dout  output  WIDTH  oldest stored sample; the last register of the last segment.

## Operation
- Storage: DEPTH registers of WIDTH bits, split into one head segment (SRLEN) and NUM = DEPTH/SRLEN−1 body segments (SRLEN each).
- Segment connections: head output feeds body[0]; body[k] feeds body[k+1]. dout is the tail of body[NUM−1], or of the head when NUM = 0.
- Shift (rst=0, en=1):
  - reg[0] ← din;
  - reg[i] ← reg[i−1] for i = 1..DEPTH−1.
- Hold (rst=0, en=0): every register keeps its value; dout is stable.
- Reset (rst=1): every register ← 0 regardless of en. rst has priority over en.
- No arithmetic and no data transformation: the output bit pattern is identical to the input bit pattern.
- Parameter violations are elaboration errors: DEPTH % SRLEN ≠ 0, or DEPTH < SRLEN.

## Timing
- dout is a pure register output with no combinational path from din or en.
- Reset value: dout = 0 and all internal registers = 0 on the edge after rst is sampled high.
- Latency: din sampled on enabled edge n appears on dout immediately after enabled edge n+DEPTH−1. Equivalently, dout equals the sample taken DEPTH enabled edges earlier, counting the capture edge.
- After reset, with en held high: dout = 0 for the first DEPTH−1 enabled edges; the first captured sample appears after edge DEPTH.
- Disabled cycles do not count toward latency; the pipeline position is frozen while en=0.
- Reset mid-operation: all in-flight data is discarded. Refill behaves exactly as after initial reset.
- Steady state: throughput is one sample per enabled cycle, sustained indefinitely.

## Configuration
- DELAYBUF_PROBE_EN:
  - Defined: the top level and every segment contain a `probe` interface instance carrying a read-only `monitor` view of its register contents and of en/rst. Bound monitors and debug printers use this view.
  - Undefined: no probe logic is generated.
- dout and timing are identical with and without the macro.

## Structure
- Shared constants package holds:
  - WIDTH, SRLEN, FFT_LEN, PERIOD;
  - the segment probe typedef (sr_probe_t) used by monitors.
- Natural sub-module: `delay_sr_seg` (SRLEN×WIDTH shift register with en/rst). It is instantiated as `headSR` and as a generate array `gen_delay.sr[0..NUM−1]`.

## Test plan
- Fill and stream: reset for one cycle, then en=1 with din = 0,1,2,… on successive edges (DEPTH=64, SRLEN=8). Required: dout = 0 for edges 1–63; after edge 64 dout = 0x0000, after edge 65 dout = 0x0001; dout tracks din−64 for 128 further cycles with zero mismatches.
- Reset value: drive din=0xFFFF with rst=1 for 3 cycles. Required: dout=0 and every segment register 0.
- Enable stall: stream 0..99, then en=0 for 10 cycles. Required: dout frozen at 36 during the stall; after en returns high, the next value is 37.
- Mid-stream reset: stream 0..79, assert rst for 1 cycle, then resume with 200,201,…. Required: dout = 0 for 63 enabled edges, then 200.
- Degenerate geometry: DEPTH=SRLEN=8 (NUM=0). Required: stream 0..31 gives dout = din delayed by 8.
- Probe build: compile with DELAYBUF_PROBE_EN. Required: the segment views concatenate in order to the last DEPTH inputs, newest in head[0], and dout matches the build without the macro.

Source files
------------

// File: rtl/delay_buf_pkg.sv
// Shared constants and probe types for the delay_buf delay line.
// The optional DELAYBUF_PROBE_EN build uses sr_probe_t in monitors.
package delay_buf_pkg;

    localparam int WIDTH   = 16;
    localparam int SRLEN   = 8;
    localparam int FFT_LEN = 64;
    localparam int PERIOD  = 10;

    typedef struct packed {
        logic                        en;
        logic                        rst;
        logic [SRLEN-1:0][WIDTH-1:0] regs;
    } sr_probe_t;

    // Number of body segments behind the head segment.
    function automatic int seg_count(input int depth, input int srlen);
        return (depth / srlen) - 32'sd1;
    endfunction

endpackage

// File: rtl/delay_buf_if.sv
// Data port bundle for delay_buf plus the read-only register probe
// view generated when DELAYBUF_PROBE_EN is defined.
interface delay_buf_if #(
    parameter int WIDTH = delay_buf_pkg::WIDTH
) ();
    logic             en;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;

    modport master (output en, output din, input dout);
    modport slave  (input en, input din, output dout);
endinterface

interface delay_probe_if #(
    parameter int NREG  = delay_buf_pkg::SRLEN,
    parameter int WIDTH = delay_buf_pkg::WIDTH
) ();
    logic [NREG-1:0][WIDTH-1:0] regs;
    logic                       en;
    logic                       rst;

    modport monitor (input regs, input en, input rst);
endinterface

// File: rtl/delay_sr_seg.sv
// One SRLEN x WIDTH shift-register segment of the delay_buf chain.
// With DELAYBUF_PROBE_EN defined it exposes its registers through a probe.
module delay_sr_seg #(
    parameter int SRLEN = delay_buf_pkg::SRLEN,
    parameter int WIDTH = delay_buf_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    import delay_buf_pkg::*;

    logic [SRLEN-1:0][WIDTH-1:0] shift_r;

    // Shift chain: index 0 holds the newest sample; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r <= '0;
        end else if (en) begin
            shift_r[0] <= din;
            for (int i = 1; i < SRLEN; i++) begin
                shift_r[i] <= shift_r[i-1];
            end
        end else begin
            shift_r <= shift_r;
        end
    end

    assign dout = shift_r[SRLEN-1];

`ifdef DELAYBUF_PROBE_EN
    delay_probe_if #(.NREG(SRLEN), .WIDTH(WIDTH)) probe ();
    assign probe.regs = shift_r;
    assign probe.en   = en;
    assign probe.rst  = rst;
`endif

endmodule

// File: rtl/delay_buf.sv
// Fixed-latency enable-gated delay line: head segment plus DEPTH/SRLEN-1
// body segments. Optional register probe view under DELAYBUF_PROBE_EN.
module delay_buf #(
    parameter int DEPTH = delay_buf_pkg::FFT_LEN,
    parameter int SRLEN = delay_buf_pkg::SRLEN,
    parameter int WIDTH = delay_buf_pkg::WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    delay_buf_if.slave bus
);
    import delay_buf_pkg::*;

    localparam int NUM = seg_count(DEPTH, SRLEN);

    if ((SRLEN < 1) || (DEPTH < SRLEN) || ((DEPTH % SRLEN) != 0)) begin : gen_param_err
        $error("delay_buf: DEPTH must be a positive multiple of SRLEN");
    end

`ifdef DELAYBUF_PROBE_EN
    delay_probe_if #(.NREG(DEPTH), .WIDTH(WIDTH)) probe ();
    assign probe.regs[SRLEN-1:0] = headSR.probe.regs;
    assign probe.en              = bus.en;
    assign probe.rst             = rst;
`endif

    logic [WIDTH-1:0] head_dout_s;

    delay_sr_seg #(.SRLEN(SRLEN), .WIDTH(WIDTH)) headSR (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .din  (bus.din),
        .dout (head_dout_s)
    );

    if (NUM > 0) begin : gen_delay
        logic [WIDTH-1:0] link_s [0:NUM];

        assign link_s[0] = head_dout_s;

        for (genvar k = 0; k < NUM; k++) begin : sr
            delay_sr_seg #(.SRLEN(SRLEN), .WIDTH(WIDTH)) seg (
                .clk  (clk),
                .rst  (rst),
                .en   (bus.en),
                .din  (link_s[k]),
                .dout (link_s[k+1])
            );
`ifdef DELAYBUF_PROBE_EN
            assign probe.regs[(k+1)*SRLEN +: SRLEN] = seg.probe.regs;
`endif
        end

        assign bus.dout = link_s[NUM];
    end else begin : gen_direct
        // Single-segment geometry: the head tail is the output.
        assign bus.dout = head_dout_s;
    end

endmodule

// File: tb/tb_delay_buf.sv
// Scoreboard bench for delay_buf: a DEPTH=64 instance and a degenerate
// DEPTH=SRLEN=8 instance share one directed stimulus stream.
module tb_delay_buf;
    import delay_buf_pkg::*;

    localparam int D1 = 64;
    localparam int D2 = 8;
    localparam int W  = 16;

    typedef struct {
        logic [W-1:0] e1;
        logic [W-1:0] e2;
        string        tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    delay_buf_if #(.WIDTH(W)) bus  ();
    delay_buf_if #(.WIDTH(W)) bus2 ();

    assign bus2.en  = bus.en;
    assign bus2.din = bus.din;

    delay_buf #(.DEPTH(D1), .SRLEN(8), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    delay_buf #(.DEPTH(D2), .SRLEN(D2), .WIDTH(W)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #(PERIOD/2) clk = ~clk;

    exp_t         exp_q [$];
    logic [W-1:0] log_q [$];
    int           k_en;
    int           vectors     = 0;
    int           miscompares = 0;

    // Reference: after k enabled edges since reset, dout is the sample captured
    // DEPTH enabled edges earlier (counting the capture edge), else zero.
    task automatic step(input logic r, input logic e, input logic [W-1:0] d, input string tag);
        exp_t x;
        @(negedge clk);
        rst     = r;
        bus.en  = e;
        bus.din = d;
        if (r) begin
            log_q.delete();
            k_en = 0;
        end else if (e) begin
            log_q.push_back(d);
            k_en++;
        end
        x.e1  = (k_en >= D1) ? log_q[k_en-D1] : 16'h0000;
        x.e2  = (k_en >= D2) ? log_q[k_en-D2] : 16'h0000;
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    // Monitor: one expected entry per edge driven by step().
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            vectors++;
            if (bus.dout !== x.e1) begin
                miscompares++;
                $display("FAIL %s dout64: got %h expected %h", x.tag, bus.dout, x.e1);
            end
            vectors++;
            if (bus2.dout !== x.e2) begin
                miscompares++;
                $display("FAIL %s dout8: got %h expected %h", x.tag, bus2.dout, x.e2);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.din = 16'h0000;
        k_en    = 0;

        // Reset with en high and all-ones data: reset must win.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'hFFFF, "reset");
        @(posedge clk);
        #2;
        vectors++;
        if (dut.headSR.shift_r !== '0) begin
            miscompares++;
            $display("FAIL reset_head_regs: got %h expected 0", dut.headSR.shift_r);
        end
        vectors++;
        if (dut.gen_delay.sr[6].seg.shift_r !== '0) begin
            miscompares++;
            $display("FAIL reset_tail_regs: got %h expected 0", dut.gen_delay.sr[6].seg.shift_r);
        end

        // Fill and stream 64 + 128 samples.
        for (int i = 0; i < 192; i++) step(1'b0, 1'b1, 16'(i), "fill_stream");

        // Stall: stream 0..99, hold 10 cycles (dout frozen at 36), resume with 37.
        step(1'b1, 1'b0, 16'h0000, "stall_reset");
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 16'(i), "stall_pre");
        for (int i = 0; i < 10; i++)  step(1'b0, 1'b0, 16'hDEAD, "stall_hold");
        for (int i = 100; i < 105; i++) step(1'b0, 1'b1, 16'(i), "stall_resume");

        // Mid-stream reset: stream 0..79, reset one cycle, refill from 200.
        step(1'b1, 1'b0, 16'h0000, "mid_reset0");
        for (int i = 0; i < 80; i++) step(1'b0, 1'b1, 16'(i), "mid_pre");
        step(1'b1, 1'b1, 16'h5A5A, "mid_reset");
        for (int i = 200; i < 270; i++) step(1'b0, 1'b1, 16'(i), "mid_refill");

        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end

`ifdef DELAYBUF_PROBE_EN
        begin
            int bad = 0;
            for (int i = 0; i < D1; i++) begin
                if (dut.probe.regs[i] !== log_q[k_en-1-i]) bad++;
            end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL probe_view: got %0d wrong registers expected 0", bad);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
